// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported synchronous word RAM between instruction fetch (A)
// and load/store (B); zero-fills the low INIT_WORDS words after reset before serving.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int INIT_WORDS = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enA,
    input  logic [31:0]       pcIn,
    input  logic [1:0]        memOp,
    input  logic [31:0]       addrB,
    input  logic [31:0]       dinB,
    output logic              gntA,
    output logic              gntB,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic              aValid,
    output logic [31:0]       doutB,
    output logic              bValid,
    output logic              NOTready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [SW-1:0]     STREAK_ONE = SW'(1);
    localparam logic [ADDR_W-1:0] INIT_LAST  = ADDR_W'(INIT_WORDS - 1);
    localparam logic [ADDR_W-1:0] INIT_ONE   = ADDR_W'(1);

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic [ADDR_W-1:0] init_cnt_r;
    logic [SW-1:0]     streak_r;
    logic              pend_a_r;
    logic              pend_b_r;
    logic [31:0]       pend_pc_r;

    logic              req_a_s;
    logic              req_b_s;
    logic              is_store_s;
    logic              is_load_s;
    logic              streak_full_s;
    logic [ADDR_W-1:0] idx_a_s;
    logic [ADDR_W-1:0] idx_b_s;

    // Byte offset and bits above the RAM size are dropped, so addresses wrap.
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{addrB[31:ADDR_W+2], addrB[1:0]};

    // Request decode and word-index extraction.
    always_comb begin
        req_a_s       = enA;
        req_b_s       = (memOp != MEM_DISABLE);
        is_store_s    = (memOp == MEM_WRITE);
        is_load_s     = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
        streak_full_s = (streak_r == STREAK_MAX);
        idx_a_s       = pcIn[ADDR_W+1:2];
        idx_b_s       = addrB[ADDR_W+1:2];
    end

    // Grant selection and RAM command generation.
    always_comb begin
        gntA      = 1'b0;
        gntB      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'h0000_0000;
        NOTready  = 1'b0;
        case (state_r)
            ST_INIT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = init_cnt_r;
                mem_wdata = 32'h0000_0000;
                NOTready  = 1'b1;
            end
            ST_RUN: begin
                // Data wins contention until the streak cap hands one cycle to fetch.
                if (req_b_s && !(req_a_s && streak_full_s)) begin
                    gntB = 1'b1;
                end else if (req_a_s) begin
                    gntA = 1'b1;
                end else begin
                    gntA = 1'b0;
                    gntB = 1'b0;
                end
                if (gntB) begin
                    mem_en    = 1'b1;
                    mem_we    = is_store_s;
                    mem_addr  = idx_b_s;
                    mem_wdata = is_store_s ? dinB : 32'h0000_0000;
                end else if (gntA) begin
                    mem_en   = 1'b1;
                    mem_addr = idx_a_s;
                end else begin
                    mem_en = 1'b0;
                end
                NOTready = (req_a_s && !gntA) || (req_b_s && !gntB);
            end
            default: begin
                NOTready = 1'b1;
            end
        endcase
    end

    // Next-state logic: INIT ends after the last zero-fill write.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // FSM state and zero-fill counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + INIT_ONE;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Contended data-grant streak, saturating at the cap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_r <= {SW{1'b0}};
        end else if (state_r != ST_RUN) begin
            streak_r <= {SW{1'b0}};
        end else if (gntB && req_a_s) begin
            streak_r <= streak_full_s ? STREAK_MAX : (streak_r + STREAK_ONE);
        end else if (gntA || !req_a_s) begin
            streak_r <= {SW{1'b0}};
        end else begin
            streak_r <= streak_r;
        end
    end

    // Track reads in flight; RAM data arrives the cycle after the grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_a_r  <= 1'b0;
            pend_b_r  <= 1'b0;
            pend_pc_r <= 32'h0000_0000;
        end else begin
            pend_a_r  <= gntA;
            pend_b_r  <= gntB && is_load_s;
            pend_pc_r <= gntA ? pcIn : pend_pc_r;
        end
    end

    // Return path registers: valid pulses, data held between accesses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aValid <= 1'b0;
            bValid <= 1'b0;
            instr  <= 32'h0000_0000;
            pc     <= 32'h0000_0000;
            doutB  <= 32'h0000_0000;
        end else begin
            aValid <= pend_a_r;
            bValid <= pend_b_r;
            if (pend_a_r) begin
                instr <= mem_rdata;
                pc    <= pend_pc_r;
            end else begin
                instr <= instr;
                pc    <= pc;
            end
            if (pend_b_r) begin
                doutB <= mem_rdata;
            end else begin
                doutB <= doutB;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural RAM, per-port expectation queues
// filled by the stimulus, and a negedge monitor that pops them on aValid/bValid.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int WORDS  = 1 << ADDR_W;
    localparam logic [1:0] OP_DIS  = 2'b00;
    localparam logic [1:0] OP_SEXT = 2'b01;
    localparam logic [1:0] OP_ZEXT = 2'b10;
    localparam logic [1:0] OP_WR   = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enA = 1'b0;
    logic [31:0]       pcIn = 32'h0;
    logic [1:0]        memOp = 2'b00;
    logic [31:0]       addrB = 32'h0;
    logic [31:0]       dinB = 32'h0;
    logic              gntA, gntB, aValid, bValid, NOTready;
    logic [31:0]       instr, pc, doutB;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    logic [31:0] ram   [0:WORDS-1];
    logic [31:0] model [0:WORDS-1];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } a_exp_t;
    a_exp_t      exp_a [$];
    logic [31:0] exp_b [$];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .enA(enA), .pcIn(pcIn), .memOp(memOp),
        .addrB(addrB), .dinB(dinB), .gntA(gntA), .gntB(gntB), .instr(instr),
        .pc(pc), .aValid(aValid), .doutB(doutB), .bValid(bValid),
        .NOTready(NOTready), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation of its port.
    always @(negedge clk) begin
        if (aValid === 1'b1) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected aValid: pc %h instr %h, none expected", pc, instr);
            end else begin
                a_exp_t e;
                e = exp_a.pop_front();
                chk("aValid instr", instr, e.instr);
                chk("aValid pc", pc, e.pc);
            end
        end
        if (bValid === 1'b1) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected bValid: doutB %h, none expected", doutB);
            end else begin
                chk("bValid doutB", doutB, exp_b.pop_front());
            end
        end
    end

    task automatic push_a(input logic [31:0] p);
        a_exp_t e;
        e.instr = model[p[ADDR_W+1:2]];
        e.pc    = p;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] a);
        exp_b.push_back(model[a[ADDR_W+1:2]]);
    endtask

    // One cycle: inputs already driven, check comb outputs at negedge, advance past posedge.
    task automatic step(input string name, input logic ga, input logic gb, input logic nr,
                        input logic en, input logic we, input int idx);
        @(negedge clk);
        chk({name, " gntA"}, {31'b0, gntA}, {31'b0, ga});
        chk({name, " gntB"}, {31'b0, gntB}, {31'b0, gb});
        chk({name, " NOTready"}, {31'b0, NOTready}, {31'b0, nr});
        chk({name, " mem_en"}, {31'b0, mem_en}, {31'b0, en});
        if (en) begin
            chk({name, " mem_we"}, {31'b0, mem_we}, {31'b0, we});
            chk({name, " mem_addr"}, {22'b0, mem_addr}, idx);
        end
        @(posedge clk); #1;
    endtask

    // Pulse reset for one cycle, then walk the 32 zero-fill cycles.
    task automatic do_reset(input bit detailed);
        reset = 1'b0; enA = 1'b0; memOp = OP_DIS;
        @(posedge clk); #1;
        reset = 1'b1;
        if (detailed) begin enA = 1'b1; pcIn = 32'h0000_0010; end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (detailed || i == 0) begin
                chk("init NOTready", {31'b0, NOTready}, 32'h1);
                chk("init gntA", {31'b0, gntA}, 32'h0);
                chk("init aValid", {31'b0, aValid}, 32'h0);
            end
            if (detailed) begin
                chk("init mem_en", {31'b0, mem_en}, 32'h1);
                chk("init mem_we", {31'b0, mem_we}, 32'h1);
                chk("init mem_addr", {22'b0, mem_addr}, i);
                chk("init mem_wdata", mem_wdata, 32'h0);
            end
            @(posedge clk); #1;
        end
        enA = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic contend6(input string name);
        enA = 1'b1; pcIn = 32'h0000_0100; memOp = OP_SEXT; addrB = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            push_b(addrB);
            step({name, " B"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16);
        end
        push_a(pcIn);
        step({name, " A"}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64);
        push_b(addrB);
        step({name, " B6"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16);
        enA = 1'b0; memOp = OP_DIS;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i]   = 32'hA5A5_0000 | i;
            model[i] = 32'hA5A5_0000 | i;
        end

        // 1: reset and zero-fill, then an idle RUN cycle.
        do_reset(1'b1);
        chk("reset instr", instr, 32'h0);
        chk("reset doutB", doutB, 32'h0);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 2: fetch alone.
        enA = 1'b1; pcIn = 32'h0000_0008;
        push_a(pcIn);
        step("fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        pcIn = 32'h0000_0100;
        push_a(pcIn);
        step("fetch hi", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64);
        enA = 1'b0;

        // 3: store then load-back.
        memOp = OP_WR; addrB = 32'h0000_0040; dinB = 32'hCAFE_F00D;
        @(negedge clk); chk("store wdata", mem_wdata, 32'hCAFE_F00D);
        step("store", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16);
        model[16] = 32'hCAFE_F00D;
        memOp = OP_ZEXT;
        push_b(addrB);
        step("load", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16);
        memOp = OP_DIS;

        // 4: contention with starvation cap.
        contend6("contend");

        // 5: address wrap and ignored byte offset.
        memOp = OP_WR; addrB = 32'h0000_1004; dinB = 32'h1234_5678;
        step("wrap store", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
        model[1] = 32'h1234_5678;
        memOp = OP_ZEXT; addrB = 32'h0000_1007;
        push_b(addrB);
        step("wrap load", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        memOp = OP_DIS;
        repeat (3) @(posedge clk);
        #1;

        // 6a: fetch granted, reset next cycle discards it.
        enA = 1'b1; pcIn = 32'h0000_0008;
        step("fetch pre-reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        do_reset(1'b0);
        chk("post-reset instr", instr, 32'h0);

        // 6b: streak built up, reset, then the cap must count from zero again.
        enA = 1'b1; pcIn = 32'h0000_0100; memOp = OP_SEXT; addrB = 32'h0000_0040;
        push_b(addrB);
        step("pre B1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16);
        push_b(addrB);
        step("pre B2", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16);
        step("pre B3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16);
        do_reset(1'b0);
        contend6("after reset");

        repeat (4) @(posedge clk);
        #1;
        chk("exp_a drained", exp_a.size(), 32'h0);
        chk("exp_b drained", exp_b.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
